// File: rtl/mac_accumulator.sv
// ---------------------------------------------------------------------------
// mac_accumulator
// Sums COUNT unsigned products a*b into one result. The operands are
// registered into mul_a/mul_b for an external combinational array
// multiplier. Its product mul_p comes back in the same cycle and is added
// to the accumulator in the following state.
//
// state | meaning
// ------+--------------------------------------------------------------
// LOAD  | waiting for an operand pair; in_ready=1
// ACCUM | adding mul_p into acc; goes to OUT after the COUNT-th product
// OUT   | result presented (out_valid=1) until out_ready handshake
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : operand pair on in_a/in_b is valid
//   in_ready   : pair accepted this cycle (LOAD only)
//   in_a, in_b : unsigned operands, WIDTH bits
//   mul_a/b    : registered operands to the array multiplier
//   mul_p      : product returned by the multiplier, 2*WIDTH bits
//   out_valid  : out_sum holds a completed result
//   out_ready  : downstream accepts the result
//   out_sum    : accumulator value, ACC_W bits
// ---------------------------------------------------------------------------
module mac_accumulator #(
    parameter int WIDTH = 8,
    parameter int COUNT = 4,
    parameter int ACC_W = 2*WIDTH+4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_p,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(COUNT - 1);

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [3:0]         cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LOAD;
            acc   <= '0;
            cnt   <= '0;
            mul_a <= '0;
            mul_b <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        mul_a <= in_a;
                        mul_b <= in_b;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc + ACC_W'(mul_p);
                    // The last product wraps cnt back to zero so it never
                    // exceeds COUNT-1; OUT clears it again on handshake.
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= OUT;
                    end else begin
                        cnt   <= cnt + 4'd1;
                        state <= LOAD;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        acc   <= '0;
                        cnt   <= '0;
                        state <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Decoded from the state register only, so neither handshake output
    // depends combinationally on the handshake inputs.
    assign in_ready  = (state == LOAD);
    assign out_valid = (state == OUT);
    assign out_sum   = acc;

endmodule

// File: tb/tb_mac_accumulator.sv
// ---------------------------------------------------------------------------
// tb_mac_accumulator
// Directed and randomized bench for mac_accumulator (WIDTH=8, COUNT=4,
// ACC_W=20). The multiplier is modelled with a continuous assign. The
// expected result of each group is the plain arithmetic sum of a*b over
// the pairs the bench hands in.
// ---------------------------------------------------------------------------
module tb_mac_accumulator;

    localparam int WIDTH = 8;
    localparam int COUNT = 4;
    localparam int ACC_W = 20;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic [2*WIDTH-1:0] mul_p;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_sum;

    int errors = 0;
    int checks = 0;

    int qa[$];
    int qb[$];

    always #5 clk = ~clk;

    assign mul_p = mul_a * mul_b;

    mac_accumulator #(.WIDTH(WIDTH), .COUNT(COUNT), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Feeds the pairs in qa/qb, with up to gap_max idle cycles before each.
    // keep_valid leaves in_valid high between pairs. When check_out is set,
    // the final result is checked once the FSM reaches OUT.
    task automatic feed(input string tag, input int gap_max, input bit keep_valid,
                        input bit check_out, output int first_wait);
        longint exp_sum = 0;
        int     gaps;
        int     waited;
        first_wait = -1;
        for (int i = 0; i < qa.size(); i++) begin
            gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            for (int g = 0; g < gaps; g++) begin
                in_valid = 1'b0;
                step();
            end
            in_valid = 1'b1;
            in_a     = WIDTH'(qa[i]);
            in_b     = WIDTH'(qb[i]);
            waited   = 0;
            while (!in_ready && waited < 20) begin
                step();
                waited++;
            end
            check({tag, "_ready_before_accept"}, longint'(in_ready), 1);
            if (i == 0) first_wait = waited;
            step();
            check({tag, "_mul_a"}, longint'(mul_a), longint'(qa[i]));
            check({tag, "_mul_b"}, longint'(mul_b), longint'(qb[i]));
            check({tag, "_no_ready_after_accept"}, longint'(in_ready), 0);
            if (!keep_valid) in_valid = 1'b0;
            exp_sum += longint'(qa[i]) * longint'(qb[i]);
        end
        if (check_out) begin
            check({tag, "_valid_in_accum"}, longint'(out_valid), 0);
            step();
            check({tag, "_valid"}, longint'(out_valid), 1);
            check({tag, "_sum"}, longint'(out_sum), exp_sum % (longint'(1) << ACC_W));
            check({tag, "_ready_in_out"}, longint'(in_ready), 0);
        end
    endtask

    // Completes the handshake (out_ready must already be high).
    task automatic handshake(input string tag);
        step();
        check({tag, "_valid_drop"}, longint'(out_valid), 0);
        check({tag, "_sum_clear"}, longint'(out_sum), 0);
        check({tag, "_load_ready"}, longint'(in_ready), 1);
    endtask

    task automatic set_pairs(input int n, input int a, input int b);
        qa.delete();
        qb.delete();
        for (int i = 0; i < n; i++) begin
            qa.push_back((a < 0) ? int'($urandom_range(255, 0)) : a);
            qb.push_back((b < 0) ? int'($urandom_range(255, 0)) : b);
        end
    endtask

    initial begin
        int fw;
        logic [ACC_W-1:0] held_sum;
        logic [WIDTH-1:0] held_a;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        step();
        step();
        check("reset_valid", longint'(out_valid), 0);
        check("reset_sum", longint'(out_sum), 0);
        check("reset_ready", longint'(in_ready), 1);
        check("reset_mul_a", longint'(mul_a), 0);
        check("reset_mul_b", longint'(mul_b), 0);
        rst_n = 1'b1;
        step();

        // Fixed mix with continuous in_valid: 15+63+65025+0 = 65103.
        qa = '{3, 7, 255, 0};
        qb = '{5, 9, 255, 200};
        feed("mix", 0, 1'b1, 1'b1, fw);
        handshake("mix");
        in_valid = 1'b0;
        step();

        // Largest products: 4*65025 = 260100, no wrap at 20 bits.
        set_pairs(4, 255, 255);
        feed("max", 0, 1'b0, 1'b1, fw);
        handshake("max");

        // Back-pressure: result held for 5 cycles while in_valid is high.
        set_pairs(4, -1, -1);
        out_ready = 1'b0;
        feed("bp", 1, 1'b0, 1'b1, fw);
        held_sum = out_sum;
        held_a   = mul_a;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_a     = WIDTH'($urandom_range(255, 0));
            in_b     = WIDTH'($urandom_range(255, 0));
            step();
            check("bp_hold_valid", longint'(out_valid), 1);
            check("bp_hold_sum", longint'(out_sum), longint'(held_sum));
            check("bp_hold_ready", longint'(in_ready), 0);
            check("bp_hold_mul_a", longint'(mul_a), longint'(held_a));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        handshake("bp");

        // Reset after two of four pairs discards the partial sum.
        set_pairs(2, -1, -1);
        feed("prerst", 0, 1'b0, 1'b0, fw);
        rst_n = 1'b0;
        step();
        check("midrst_valid", longint'(out_valid), 0);
        check("midrst_sum", longint'(out_sum), 0);
        check("midrst_ready", longint'(in_ready), 1);
        check("midrst_mul_a", longint'(mul_a), 0);
        rst_n = 1'b1;
        set_pairs(4, 1, 1);
        feed("postrst", 0, 1'b0, 1'b1, fw);
        handshake("postrst");

        // Random idle gaps: (2,3)x4 = 24.
        set_pairs(4, 2, 3);
        feed("gaps", 3, 1'b0, 1'b1, fw);
        handshake("gaps");

        // Back-to-back groups with out_ready tied high.
        set_pairs(4, -1, -1);
        feed("b2b1", 0, 1'b1, 1'b1, fw);
        handshake("b2b1");
        set_pairs(4, -1, -1);
        feed("b2b2", 0, 1'b1, 1'b1, fw);
        check("b2b_first_accept_wait", longint'(fw), 0);
        handshake("b2b2");
        in_valid = 1'b0;

        // Random groups with random gaps.
        for (int g = 0; g < 6; g++) begin
            set_pairs(4, -1, -1);
            feed("rand", 2, 1'b0, 1'b1, fw);
            handshake("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench did not finish");
    end

endmodule
